// File: rtl/sized_fifo_pkg.sv
// sized_fifo_pkg: shared status reset value, op-select encoding and parameter-check helper
package sized_fifo_pkg;
  typedef struct packed {
    logic full_n;
    logic empty_n;
    logic almost_full;
    logic almost_empty;
    logic ovf;
    logic udf;
  } status_t;
  localparam status_t STATUS_RST = '{full_n: 1'b1, empty_n: 1'b0, almost_full: 1'b0,
                                     almost_empty: 1'b1, ovf: 1'b0, udf: 1'b0};
  typedef struct packed {
    logic clr;
    logic deq;
    logic enq;
    logic c0;
    logic c1;
  } op_sel_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/sized_fifo_level_ring.sv
// fifo_ring_ram: sync-write / async-read ring with head/tail pointers wrapping at N-1
module fifo_ring_ram #(
  parameter int W  = 8,
  parameter int N  = 7,
  parameter int PW = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         WEN,
  input  logic         REN,
  input  logic [W-1:0] WDATA,
  output logic [W-1:0] RDATA
);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  logic [W-1:0]  mem [N];
  logic [PW-1:0] head, tail;
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (WEN) tail <= (tail == LAST) ? '0 : tail + PW'(1);
      if (REN) head <= (head == LAST) ? '0 : head + PW'(1);
    end
  end
  always_ff @(posedge CLK) if (WEN) mem[tail] <= WDATA;
  assign RDATA = mem[head];
endmodule

// File: rtl/sized_fifo_level.sv
// sized_fifo_level: sized FIFO with registered head, exact COUNT, almost flags and sticky errors
module sized_fifo_level
  import sized_fifo_pkg::*;
#(
  parameter int p1width      = 8,
  parameter int p2depth      = 8,
  parameter int p3cntr_width = 3,
  parameter int p4af_thresh  = 6,
  parameter int p5ae_thresh  = 1,
  parameter int guarded      = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic [p1width-1:0]    D_IN,
  input  logic                  ENQ,
  output logic                  FULL_N,
  output logic [p1width-1:0]    D_OUT,
  input  logic                  DEQ,
  output logic                  EMPTY_N,
  output logic [p3cntr_width:0] COUNT,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  OVF,
  output logic                  UDF
);
  localparam int CW = p3cntr_width + 1;
  localparam logic [CW-1:0] DEPTH = CW'(p2depth);
  if (p2depth < 2) begin : g_bad_depth
    $fatal(1, "sized_fifo_level: p2depth must be >= 2");
  end
  if (clog2(p2depth - 1) > p3cntr_width) begin : g_bad_width
    $fatal(1, "sized_fifo_level: p3cntr_width too small for p2depth");
  end
  if (p4af_thresh < 1 || p4af_thresh > p2depth || p5ae_thresh < 0 || p5ae_thresh > p2depth - 1)
  begin : g_bad_thresh
    $fatal(1, "sized_fifo_level: threshold out of range");
  end
  logic [CW-1:0]      count, count_nx;
  logic [p1width-1:0] d_out, ring_q;
  status_t            s;
  op_sel_t            op;
  logic full, enq_ok, deq_ok, ring_wen, ring_ren, load_din, ovf_evt, udf_evt;
  assign op       = '{clr: CLR, deq: DEQ, enq: ENQ, c0: count == '0, c1: count == CW'(1)};
  assign full     = count == DEPTH;
  assign enq_ok   = op.enq & (!full | (op.deq & (guarded == 0) & full));
  assign deq_ok   = op.deq & !op.c0;
  assign ring_wen = !op.clr & enq_ok & ((!op.c0 & !op.c1) | (op.c1 & !deq_ok));
  assign ring_ren = !op.clr & deq_ok & !op.c0 & !op.c1;
  // an empty head, or a head leaving at count 1, is refilled straight from D_IN
  assign load_din = !op.clr & enq_ok & (op.c0 | (op.c1 & deq_ok));
  assign ovf_evt  = !op.clr & op.enq & !enq_ok;
  assign udf_evt  = !op.clr & op.deq & op.c0;
  assign count_nx = op.clr ? '0 : count + CW'(enq_ok) - CW'(deq_ok);
  fifo_ring_ram #(.W(p1width), .N(p2depth - 1), .PW(p3cntr_width)) u_ring (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WEN(ring_wen), .REN(ring_ren), .WDATA(D_IN), .RDATA(ring_q)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      s     <= STATUS_RST;
      d_out <= '0;
    end else begin
      count          <= count_nx;
      s.full_n       <= count_nx != DEPTH;
      s.empty_n      <= count_nx != '0;
      s.almost_full  <= count_nx >= CW'(p4af_thresh);
      s.almost_empty <= count_nx <= CW'(p5ae_thresh);
      s.ovf          <= s.ovf | ovf_evt;
      s.udf          <= s.udf | udf_evt;
      d_out          <= load_din ? D_IN : ring_ren ? ring_q : d_out;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST && ovf_evt) $warning("sized_fifo_level: enqueue dropped (overflow)");
    if (!RST && udf_evt) $warning("sized_fifo_level: dequeue while empty (underflow)");
  end
  assign COUNT        = count;
  assign D_OUT        = d_out;
  assign FULL_N       = s.full_n;
  assign EMPTY_N      = s.empty_n;
  assign ALMOST_FULL  = s.almost_full;
  assign ALMOST_EMPTY = s.almost_empty;
  assign OVF          = s.ovf;
  assign UDF          = s.udf;
endmodule

// File: tb/tb_sized_fifo_level.sv
// tb_sized_fifo_level: guarded and unguarded instances driven alike, checked against a queue model
module tb_sized_fifo_level;
  localparam int W = 8, DEPTH = 8, CW = 4, AF = 6, AE = 1;
  logic CLK = 0, RST = 1, CLR = 0, ENQ = 0, DEQ = 0;
  logic [W-1:0] D_IN = '0;
  logic [W-1:0]  dout [2];
  logic [CW-1:0] cnt [2];
  logic full_n [2], empty_n [2], af [2], ae [2], ovf [2], udf [2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sized_fifo_level #(.p1width(W), .p2depth(DEPTH), .p3cntr_width(CW - 1), .p4af_thresh(AF),
                       .p5ae_thresh(AE), .guarded(g == 0 ? 1 : 0)) u_dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .D_IN(D_IN), .ENQ(ENQ), .FULL_N(full_n[g]),
      .D_OUT(dout[g]), .DEQ(DEQ), .EMPTY_N(empty_n[g]), .COUNT(cnt[g]),
      .ALMOST_FULL(af[g]), .ALMOST_EMPTY(ae[g]), .OVF(ovf[g]), .UDF(udf[g])
    );
  end
  always #5 CLK = ~CLK;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] m [2][DEPTH];
  int           n [2];
  logic [W-1:0] md [2];
  logic         mo [2], mu [2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    for (int g = 0; g < 2; g++) begin
      if (RST) begin
        n[g] = 0; md[g] = '0; mo[g] = 0; mu[g] = 0;
      end else if (CLR) begin
        n[g] = 0;
      end else begin
        int c;
        bit eok, dok;
        c   = n[g];
        eok = ENQ && (c < DEPTH || (DEQ && g == 1 && c == DEPTH));
        dok = DEQ && c > 0;
        if (ENQ && !eok) mo[g] = 1;
        if (DEQ && c == 0) mu[g] = 1;
        if (dok) begin
          for (int k = 0; k < DEPTH - 1; k++) m[g][k] = m[g][k+1];
          n[g]--;
        end
        if (eok) begin
          m[g][n[g]] = D_IN;
          n[g]++;
        end
        if (n[g] > 0) md[g] = m[g][0];
      end
    end
  endtask
  task automatic cyc(input logic e, input logic d, input logic c, input logic r, input logic [W-1:0] v);
    ENQ = e; DEQ = d; CLR = c; RST = r; D_IN = v;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      logic [31:0] got, exp;
      got = 32'({cnt[g], full_n[g], empty_n[g], af[g], ae[g], ovf[g], udf[g], dout[g]});
      exp = 32'({4'(n[g]), n[g] != DEPTH, n[g] != 0, n[g] >= AF, n[g] <= AE, mo[g], mu[g], md[g]});
      check(g == 0 ? "guarded" : "unguarded", got, exp);
    end
  endtask
  initial begin
    @(negedge CLK);
    cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, W'(i));
    cyc(1, 0, 0, 0, 8'hFF);
    repeat (8) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, W'(8'h40 + i));
    cyc(1, 1, 0, 0, 8'hAA);
    repeat (8) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, W'(8'h10 + i));
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, W'(8'h20 + i));
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 8'h55);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, W'(8'h60 + i));
    cyc(1, 1, 1, 0, 8'h77);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      int pe;
      pe = ((k / 60) % 2) ? 75 : 30;
      cyc($urandom_range(0, 99) < pe, $urandom_range(0, 99) < 100 - pe,
          $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1, W'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
